seq_sub64: RTL

- Iterative, handshaked 64-bit signed subtractor computing d = a - b - bi. It is the inverse-direction companion to the combinational carry-select adder.
- Processes one SLICE_W-bit carry-select slice per clock, trading latency for area.
- Sits between an operand producer and a result consumer on valid/ready interfaces, so the datapath can stall without losing results.

---
 rtl/seq_sub64_pkg.sv | 24 ++
 rtl/csel_sub_slice.sv | 23 ++
 rtl/seq_sub64.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seq_sub64_pkg.sv
// Shared state encoding, counter sizing and saturation limits for seq_sub64.
// The saturation limits are only consumed when SEQ_SUB64_SAT_EN is defined.
package seq_sub64_pkg;

    localparam int DEF_WIDTH   = 64;
    localparam int DEF_SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    // Slice counter width; a single-slice build still needs one bit.
    function automatic int cnt_w(input int width, input int slice_w);
        int n;
        n = width / slice_w;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csel_sub_slice.sv
// Combinational carry-select subtract slice: both borrow-in results are formed
// in parallel and the incoming borrow only drives the final select.
module csel_sub_slice #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] diff,
    output logic               borrow_out
);

    logic [SLICE_W:0] sum_nb;
    logic [SLICE_W:0] sum_b;

    // x - y - bin == x + ~y + !bin; a carry out means no borrow.
    assign sum_nb = {1'b0, x} + {1'b0, ~y} + {{SLICE_W{1'b0}}, 1'b1};
    assign sum_b  = {1'b0, x} + {1'b0, ~y};

    assign diff       = borrow_in ? sum_b[SLICE_W-1:0] : sum_nb[SLICE_W-1:0];
    assign borrow_out = borrow_in ? ~sum_b[SLICE_W]    : ~sum_nb[SLICE_W];

endmodule

// File: rtl/seq_sub64.sv
// Iterative handshaked signed subtractor d = a - b - bi, one slice per cycle.
// Define SEQ_SUB64_SAT_EN to saturate d on signed overflow and expose the sat port.
module seq_sub64
    import seq_sub64_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    bi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] d,
    output logic                    bo,
    output logic                    ovf
`ifdef SEQ_SUB64_SAT_EN
    ,
    output logic                    sat
`endif
);

    localparam int             N    = WIDTH / SLICE_W;
    localparam int             CW   = cnt_w(WIDTH, SLICE_W);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     borrow_q, borrow_d;
    logic signed [WIDTH-1:0]  a_q, a_d;
    logic signed [WIDTH-1:0]  b_q, b_d;
    logic signed [WIDTH-1:0]  d_q, d_d;
    logic                     bo_q, bo_d;
    logic                     ovf_q, ovf_d;
`ifdef SEQ_SUB64_SAT_EN
    logic                     sat_q, sat_d;
`endif

    logic [SLICE_W-1:0]       x_s, y_s, diff_s;
    logic                     borrow_s;
    logic signed [WIDTH-1:0]  d_full;
    logic                     ovf_fin;

`ifdef SEQ_SUB64_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(SAT_MAX >> (DEF_WIDTH - WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(SAT_MIN >> (DEF_WIDTH - WIDTH));

    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] val,
        input logic                    ovf_in,
        input logic                    a_neg
    );
        if (!ovf_in) return val;
        return a_neg ? SAT_LO : SAT_HI;
    endfunction
`endif

    assign x_s = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign y_s = b_q[cnt_q*SLICE_W +: SLICE_W];

    csel_sub_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .x          (x_s),
        .y          (y_s),
        .borrow_in  (borrow_q),
        .diff       (diff_s),
        .borrow_out (borrow_s)
    );

    always_comb begin
        d_full = d_q;
        d_full[cnt_q*SLICE_W +: SLICE_W] = diff_s;
    end

    // Only meaningful on the last slice, where d_full is the complete result.
    assign ovf_fin = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_full[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        bo_d     = bo_q;
        ovf_d    = ovf_q;
`ifdef SEQ_SUB64_SAT_EN
        sat_d    = sat_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bi;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                d_d      = d_full;
                borrow_d = borrow_s;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    bo_d    = borrow_s;
                    ovf_d   = ovf_fin;
                    state_d = DONE;
`ifdef SEQ_SUB64_SAT_EN
                    d_d     = saturate(d_full, ovf_fin, a_q[WIDTH-1]);
                    sat_d   = ovf_fin;
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SEQ_SUB64_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            ovf_q    <= ovf_d;
`ifdef SEQ_SUB64_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    // Operands are only read after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bo        = bo_q;
    assign ovf       = ovf_q;
`ifdef SEQ_SUB64_SAT_EN
    assign sat       = sat_q;
`endif

endmodule
